// File: rtl/brownout_dig_if.sv
// Signal bundle between the brownout digital back end and its surroundings.
// The master side drives control and comparator inputs; the slave (brownout_dig)
// returns the decoded trip words and the detector outputs.
interface brownout_dig_if;
  logic       ena;
  logic       dcomp;
  logic [2:0] otrip;
  logic [2:0] vtrip;
  logic       force_short_oneshot;
  logic       clear_flag;
  logic [7:0] otrip_decoded;
  logic [7:0] vtrip_decoded;
  logic       brout_det;
  logic       out_unbuf;
  logic       brout_flag;

  modport master (
    output ena,
    output dcomp,
    output otrip,
    output vtrip,
    output force_short_oneshot,
    output clear_flag,
    input  otrip_decoded,
    input  vtrip_decoded,
    input  brout_det,
    input  out_unbuf,
    input  brout_flag
  );

  modport slave (
    input  ena,
    input  dcomp,
    input  otrip,
    input  vtrip,
    input  force_short_oneshot,
    input  clear_flag,
    output otrip_decoded,
    output vtrip_decoded,
    output brout_det,
    output out_unbuf,
    output brout_flag
  );
endinterface

// File: rtl/brownout_dig.sv
// Brownout detector digital back end: trip-select decode, comparator
// resynchronisation and debounce, assert/hold one-shot and sticky flag.
module brownout_dig #(
  parameter int unsigned FILT_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES = 2000,
  parameter int unsigned HOLD_SHORT  = 8,
  parameter int unsigned CNT_W       = 12
) (
  input logic           osc_ck,
  input logic           rst,
  brownout_dig_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StArmed, StAssert, StHold} state_e;

  localparam logic [CNT_W-1:0] FiltLast  = CNT_W'(FILT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HoldLong  = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] HoldShort = CNT_W'(HOLD_SHORT);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  state_e           state_q, state_d;
  logic             s1_q, s2_q;
  logic             det_q, det_d;
  logic [CNT_W-1:0] filt_cnt_q, filt_cnt_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] hold_len_q, hold_len_d;
  logic             out_q, out_d;
  logic             flag_q, flag_d;
  logic [7:0]       otrip_dec_q, vtrip_dec_q;

  // Trip-select decode; words freeze while disabled.
  always_ff @(posedge osc_ck or posedge rst) begin
    if (rst) begin
      otrip_dec_q <= 8'h01;
      vtrip_dec_q <= 8'h01;
    end else if (bus.ena) begin
      otrip_dec_q <= 8'h01 << bus.otrip;
      vtrip_dec_q <= 8'h01 << bus.vtrip;
    end
  end

  // Two-flop resynchroniser for the asynchronous comparator output.
  always_ff @(posedge osc_ck or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else if (!bus.ena) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= bus.dcomp;
      s2_q <= s1_q;
    end
  end

  // Debounce: brout_det follows s2 only after FILT_CYCLES consecutive disagreements.
  always_comb begin
    det_d      = det_q;
    filt_cnt_d = '0;
    if (!bus.ena) begin
      det_d = 1'b0;
    end else if (s2_q != det_q) begin
      if (filt_cnt_q == FiltLast) begin
        det_d = ~det_q;
      end else begin
        filt_cnt_d = filt_cnt_q + CntOne;
      end
    end
  end

  // Assert/hold sequencing; hold length is latched on HOLD entry so a later
  // change of force_short_oneshot cannot stretch or cut the running hold.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    hold_len_d = hold_len_q;
    unique case (state_q)
      StIdle: state_d = StArmed;
      StArmed: begin
        if (det_q) state_d = StAssert;
      end
      StAssert: begin
        if (!det_q) begin
          state_d    = StHold;
          hold_cnt_d = '0;
          hold_len_d = bus.force_short_oneshot ? HoldShort : HoldLong;
        end
      end
      StHold: begin
        if (det_q) begin
          state_d    = StAssert;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == hold_len_q - CntOne) begin
          state_d    = StArmed;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + CntOne;
        end
      end
      default: state_d = StIdle;
    endcase
    if (!bus.ena) begin
      state_d    = StIdle;
      hold_cnt_d = '0;
    end
  end

  // Output and sticky flag; a set on ASSERT entry beats a coincident clear.
  always_comb begin
    out_d  = (state_d == StAssert) || (state_d == StHold);
    flag_d = flag_q;
    if ((state_d == StAssert) && (state_q != StAssert)) begin
      flag_d = 1'b1;
    end else if (bus.clear_flag) begin
      flag_d = 1'b0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge osc_ck or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      det_q      <= 1'b0;
      filt_cnt_q <= '0;
      hold_cnt_q <= '0;
      hold_len_q <= '0;
      out_q      <= 1'b0;
      flag_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      det_q      <= det_d;
      filt_cnt_q <= filt_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      hold_len_q <= hold_len_d;
      out_q      <= out_d;
      flag_q     <= flag_d;
    end
  end

  assign bus.otrip_decoded = otrip_dec_q;
  assign bus.vtrip_decoded = vtrip_dec_q;
  assign bus.brout_det     = det_q;
  assign bus.out_unbuf     = out_q;
  assign bus.brout_flag    = flag_q;

endmodule

// File: tb/tb_brownout_dig.sv
// Directed bench for brownout_dig with a cycle-level behavioural reference.
module tb_brownout_dig;
  localparam int unsigned Filt      = 4;
  localparam int unsigned HoldLong  = 2000;
  localparam int unsigned HoldShort = 8;

  logic osc_ck = 1'b0;
  logic rst    = 1'b0;

  brownout_dig_if bus ();

  brownout_dig #(
    .FILT_CYCLES (Filt),
    .HOLD_CYCLES (HoldLong),
    .HOLD_SHORT  (HoldShort),
    .CNT_W       (12)
  ) dut (
    .osc_ck (osc_ck),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 osc_ck = ~osc_ck;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge osc_ck);
      #2;
    end
  endtask

  // Reference: s1/s2 delay line, a run length of disagreement for the debounce,
  // and a countdown of remaining hold edges for the one-shot.
  logic       m_s1 = 1'b0, m_s2 = 1'b0, m_det = 1'b0, m_out = 1'b0;
  logic       m_flag = 1'b0, m_asserting = 1'b0;
  int         m_run = 0, m_rem = 0;
  logic [7:0] m_otd = 8'h01, m_vtd = 8'h01;
  logic       p_s2, p_det, p_entry;
  int         p_run;

  always @(posedge osc_ck) begin
    if (rst) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_det = 1'b0; m_out = 1'b0;
      m_flag = 1'b0; m_asserting = 1'b0; m_run = 0; m_rem = 0;
      m_otd = 8'h01; m_vtd = 8'h01;
    end else begin
      p_s2 = m_s2; p_det = m_det; p_run = m_run; p_entry = 1'b0;
      if (!bus.ena) begin
        m_s1 = 1'b0; m_s2 = 1'b0; m_det = 1'b0; m_run = 0;
        m_out = 1'b0; m_rem = 0; m_asserting = 1'b0;
      end else begin
        m_s2 = m_s1;
        m_s1 = bus.dcomp;
        if (p_s2 != p_det) begin
          if (p_run == int'(Filt) - 1) begin
            m_det = ~p_det;
            m_run = 0;
          end else begin
            m_run = p_run + 1;
          end
        end else begin
          m_run = 0;
        end
        if (p_det) begin
          p_entry     = !m_asserting;
          m_asserting = 1'b1;
          m_rem       = 0;
          m_out       = 1'b1;
        end else if (m_asserting) begin
          m_asserting = 1'b0;
          m_rem       = bus.force_short_oneshot ? int'(HoldShort) : int'(HoldLong);
          m_out       = 1'b1;
        end else if (m_rem > 0) begin
          m_rem = m_rem - 1;
          m_out = (m_rem > 0);
        end else begin
          m_out = 1'b0;
        end
        m_otd = 8'h01 << bus.otrip;
        m_vtd = 8'h01 << bus.vtrip;
      end
      if (p_entry) m_flag = 1'b1;
      else if (bus.clear_flag) m_flag = 1'b0;
    end
    #1;
    chk("otrip_decoded", 32'(bus.otrip_decoded), 32'(m_otd));
    chk("vtrip_decoded", 32'(bus.vtrip_decoded), 32'(m_vtd));
    chk("brout_det", 32'(bus.brout_det), 32'(m_det));
    chk("out_unbuf", 32'(bus.out_unbuf), 32'(m_out));
    chk("brout_flag", 32'(bus.brout_flag), 32'(m_flag));
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_hi;
    int n_edges;
    logic seen;

    bus.ena = 1'b0;
    bus.dcomp = 1'b0;
    bus.otrip = 3'd0;
    bus.vtrip = 3'd0;
    bus.force_short_oneshot = 1'b0;
    bus.clear_flag = 1'b0;

    // Reset values, before and during clocking.
    #1 rst = 1'b1;
    #1;
    chk("rst out_unbuf", 32'(bus.out_unbuf), 32'd0);
    chk("rst otrip_decoded", 32'(bus.otrip_decoded), 32'h01);
    tick(2);
    chk("rst vtrip_decoded", 32'(bus.vtrip_decoded), 32'h01);
    chk("rst brout_flag", 32'(bus.brout_flag), 32'd0);

    // Decode after one edge.
    rst = 1'b0;
    bus.ena = 1'b1;
    bus.otrip = 3'd5;
    bus.vtrip = 3'd2;
    tick(1);
    chk("dec otrip 5", 32'(bus.otrip_decoded), 32'h20);
    chk("dec vtrip 2", 32'(bus.vtrip_decoded), 32'h04);

    // Assert latency: brout_det after edge 5, out_unbuf after edge 6.
    bus.force_short_oneshot = 1'b1;
    bus.dcomp = 1'b1;
    tick(5);
    chk("lat det edge4", 32'(bus.brout_det), 32'd0);
    tick(1);
    chk("lat det edge5", 32'(bus.brout_det), 32'd1);
    chk("lat out edge5", 32'(bus.out_unbuf), 32'd0);
    tick(1);
    chk("lat out edge6", 32'(bus.out_unbuf), 32'd1);
    chk("lat flag", 32'(bus.brout_flag), 32'd1);

    // Short hold: high through edge 13 after the fall, 14 edges in all.
    bus.dcomp = 1'b0;
    n_hi = 0;
    repeat (30) begin
      tick(1);
      if (bus.out_unbuf) n_hi++;
    end
    chk("short hold edges", 32'(n_hi), 32'd14);

    bus.clear_flag = 1'b1;
    tick(1);
    bus.clear_flag = 1'b0;
    chk("flag cleared", 32'(bus.brout_flag), 32'd0);

    // Glitch of 3 cycles is rejected.
    bus.dcomp = 1'b1;
    tick(3);
    bus.dcomp = 1'b0;
    tick(10);
    chk("glitch det", 32'(bus.brout_det), 32'd0);
    chk("glitch out", 32'(bus.out_unbuf), 32'd0);
    chk("glitch flag", 32'(bus.brout_flag), 32'd0);

    // Assert with clear_flag on the ASSERT-entry edge: set wins.
    bus.dcomp = 1'b1;
    tick(6);
    bus.clear_flag = 1'b1;
    tick(1);
    bus.clear_flag = 1'b0;
    chk("collide out", 32'(bus.out_unbuf), 32'd1);
    chk("collide flag", 32'(bus.brout_flag), 32'd1);

    // Re-trigger: brout_det returns early in the hold, then a full new hold.
    bus.dcomp = 1'b0;
    tick(5);
    bus.dcomp = 1'b1;
    n_hi = 0;
    repeat (12) begin
      tick(1);
      if (bus.out_unbuf) n_hi++;
    end
    chk("retrigger kept high", 32'(n_hi), 32'd12);
    chk("retrigger det", 32'(bus.brout_det), 32'd1);
    bus.dcomp = 1'b0;
    n_hi = 0;
    repeat (30) begin
      tick(1);
      if (bus.out_unbuf) n_hi++;
    end
    chk("retrigger new hold", 32'(n_hi), 32'd14);

    // Long hold; flipping force_short_oneshot mid-hold must not shorten it.
    bus.force_short_oneshot = 1'b0;
    bus.dcomp = 1'b1;
    tick(8);
    bus.dcomp = 1'b0;
    n_hi = 0;
    for (int i = 0; i < 2100; i++) begin
      if (i == 10) bus.force_short_oneshot = 1'b1;
      tick(1);
      if (bus.out_unbuf) n_hi++;
    end
    chk("long hold edges", 32'(n_hi), 32'd2006);

    // Disable while asserted, then requalify through the full path.
    bus.dcomp = 1'b1;
    tick(7);
    chk("pre-disable out", 32'(bus.out_unbuf), 32'd1);
    bus.ena = 1'b0;
    bus.otrip = 3'd1;
    bus.vtrip = 3'd6;
    tick(1);
    chk("disable out", 32'(bus.out_unbuf), 32'd0);
    chk("disable det", 32'(bus.brout_det), 32'd0);
    chk("disable otrip held", 32'(bus.otrip_decoded), 32'h20);
    chk("disable vtrip held", 32'(bus.vtrip_decoded), 32'h04);
    tick(3);
    bus.ena = 1'b1;
    n_edges = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(1);
      n_edges++;
      if (bus.out_unbuf) seen = 1'b1;
    end
    chk("reenable seen", 32'(seen), 32'd1);
    chk("reenable edges", 32'(n_edges), 32'd7);
    chk("reenable otrip", 32'(bus.otrip_decoded), 32'h02);

    // Asynchronous reset while asserted.
    rst = 1'b1;
    #1;
    chk("async rst out", 32'(bus.out_unbuf), 32'd0);
    chk("async rst flag", 32'(bus.brout_flag), 32'd0);
    chk("async rst otrip", 32'(bus.otrip_decoded), 32'h01);
    tick(2);
    rst = 1'b0;
    tick(10);
    chk("post rst out", 32'(bus.out_unbuf), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/brownout_dig.md
# brownout_dig

Digital back end of the brownout detector. Consumes the raw brownout comparator decision `dcomp` from the analog macro and registers the 3-bit trip selections into the one-hot `otrip_decoded` / `vtrip_decoded` words that the macro's resistor-string mux uses. It resynchronises and debounces `dcomp`, runs the assert/hold state machine and drives `out_unbuf` back into the macro's output buffer. Clocked by the macro's RC oscillator output `osc_ck`.

## Interface
- `FILT_CYCLES`, default 4: consecutive cycles a synchronised `dcomp` change must persist before the filtered value `brout_det` follows it; legal range ≥1.
- `HOLD_CYCLES`, default 2000: cycles `out_unbuf` stays high after the brownout clears, normal mode.
- `HOLD_SHORT`, default 8: the same hold, used when `force_short_oneshot`=1.
- `CNT_W`, default 12: width of the filter counter and the hold counter; must hold `max(HOLD_CYCLES, FILT_CYCLES)`.
- `osc_ck` in 1: clock, RC oscillator. One clock; all state changes on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `ena` in 1: block enable, quasi-static, sampled on `osc_ck`.
- `dcomp` in 1: raw comparator output, asynchronous; 1 = supply below the `otrip` threshold.
- `otrip` in 3: brownout trip select, binary.
- `vtrip` in 3: undervoltage trip select, binary.
- `force_short_oneshot` in 1: selects `HOLD_SHORT` for the hold.
- `clear_flag` in 1: clears the sticky flag, single-cycle pulse.
- `otrip_decoded` out 8: registered one-hot of `otrip`.
- `vtrip_decoded` out 8: registered one-hot of `vtrip`.
- `brout_det` out 1: filtered brownout.
- `out_unbuf` out 1: brownout output to the macro buffer.
- `brout_flag` out 1: sticky, set whenever a brownout is asserted.

## Operation
- **Reset values.** All of the following until the first edge after `rst` falls:
  - `out_unbuf`=0, `brout_det`=0, `brout_flag`=0.
  - `otrip_decoded`=`vtrip_decoded`=8'h01.
  - Synchroniser flops 0, both counters 0, state IDLE.
- **Decode.**
  - With `ena`=1, on every edge: `otrip_decoded` ← 1<<`otrip`, `vtrip_decoded` ← 1<<`vtrip`.
  - With `ena`=0, both words hold their last value.
- **Synchroniser.** 2-flop chain, `dcomp` → s1 → s2.
- **Filter.**
  - When s2≠`brout_det`, the filter counter increments; when s2=`brout_det`, it clears to 0.
  - On an edge where s2≠`brout_det` and the counter equals `FILT_CYCLES`-1: `brout_det` toggles and the counter clears.
  - Glitches shorter than `FILT_CYCLES` synchronised cycles are rejected.
- **State machine.** `out_unbuf`=1 exactly in ASSERT and HOLD.
  - IDLE: → ARMED when `ena`=1.
  - ARMED: → ASSERT when `brout_det`=1.
  - ASSERT: → HOLD when `brout_det`=0. On entry to HOLD: hold counter ← 0 and the hold length N is latched (N=`HOLD_SHORT` if `force_short_oneshot`=1, else `HOLD_CYCLES`).
  - HOLD: the hold counter increments every edge.
    - `brout_det`=1 → ASSERT; the hold is abandoned and the counter cleared.
    - Hold counter = N-1 → ARMED.
- **Disable.** `ena`=0 on any edge, from any state:
  - Effect on that edge: → IDLE; s1, s2, `brout_det`, both counters cleared; `out_unbuf` falls.
  - After `ena` returns, `dcomp` must requalify through the full synchroniser + filter path.
- **Sticky flag.**
  - `brout_flag` ← 1 on every edge that enters ASSERT.
  - `clear_flag`=1 clears it.
  - If set and clear fall on the same edge, set wins.
- **Reset mid-operation.** Returns immediately to the reset values, including dropping `out_unbuf` asynchronously.

## Timing
- **Assert latency.** `dcomp` rises and is stable before edge 0:
  - s1=1 after edge 0, s2=1 after edge 1.
  - `brout_det`=1 after edge `FILT_CYCLES`+1.
  - `out_unbuf`=1 after edge `FILT_CYCLES`+2.
- **Release latency.**
  - `brout_det` falls after edge `FILT_CYCLES`+1 relative to `dcomp` falling; HOLD is entered after edge `FILT_CYCLES`+2.
  - `out_unbuf` stays 1 for exactly N further edges, falling after edge `FILT_CYCLES`+2+N.
- **Decode latency.** `otrip_decoded` / `vtrip_decoded` follow `otrip` / `vtrip` after 1 edge.
- **`force_short_oneshot`.** Changes during HOLD do not affect the current hold.
- **Counters.** Saturation is never reached by construction; neither counter wraps.

## Test plan
- **Reset and decode.** Assert `rst` → reset values, decoded words 8'h01. Release `rst`, then `ena`=1, `otrip`=3'd5, `vtrip`=3'd2 → after one edge, `otrip_decoded`=8'h20 and `vtrip_decoded`=8'h04.
- **Assert latency.** `FILT_CYCLES`=4, `dcomp` step high → `brout_det` high after edge 5, `out_unbuf` high after edge 6, `brout_flag`=1.
- **Glitch rejection.** `dcomp` high for 3 cycles, then low → `brout_det` and `out_unbuf` stay 0, `brout_flag` stays 0.
- **Hold length.**
  - `force_short_oneshot`=1 with `HOLD_SHORT`=8: `dcomp` falls → `out_unbuf` high for exactly 8 edges after HOLD entry, then 0, state ARMED.
  - Repeat with `force_short_oneshot`=0 → 2000 edges.
- **Re-trigger and flag collision.** `dcomp` re-rises at hold edge 3 → back to ASSERT; after release, a full new 8-cycle hold. Pulse `clear_flag` on the same edge as ASSERT entry → `brout_flag` remains 1.
- **Disable.** `ena`=0 while in ASSERT → `out_unbuf` falls after that edge, `brout_det`=0, decoded words unchanged. `ena`=1 with `dcomp` still high → `out_unbuf` re-asserts after `FILT_CYCLES`+3 edges.
